calc_seq_top: RTL and testbench
===============================

CALC_SEQ_TOP -- requirements
Module: calc_seq_top

Interface
REQ-001 SHALL have parameter LANES, default 8: number of independent accumulation lanes.
REQ-002 SHALL have parameter WORDS, default 4: data words per lane per step.
REQ-003 SHALL have parameter DATA_W, default 64: width of one data word.
REQ-004 SHALL have parameter ACC_W, default 16: accumulator and result width per lane.
REQ-005 SHALL have parameter SW, default 5: signed weight element width, so weight_in is LANES*WORDS*SW bits (160 by default).
REQ-006 SHALL have parameter ADDR_W, default 32: width of every address output.
REQ-007 SHALL have parameter KW, default 8: width of the step-count input.
REQ-008 SHALL have a single clock and a synchronous, active-high reset, named clk and rst.
REQ-009 clk, input, 1: sole clock; all state updates on its rising edge.
REQ-010 rst, input, 1: synchronous active-high reset.
REQ-011 start, input, 1: single-cycle request to begin a job; honoured only in IDLE.
REQ-012 k_len, input, KW: number of accumulation steps in the job, sampled with start.
REQ-013 shift_in, input, LANES*3: per-lane left-shift amount (0..7), sampled with start.
REQ-014 weight_in, input, LANES*WORDS*SW: weight vector S; element (l,w) sits at bit offset (l*WORDS+w)*SW.
REQ-015 data_in, input, LANES*WORDS*DATA_W: data matrix A, returned one cycle after addr_A.
REQ-016 addr_A, addr_S, output, ADDR_W each: read addresses for A and S.
REQ-017 addr_B, output, ADDR_W: result index for the current job.
REQ-018 res_valid, output, 1: asserted while final_result holds a completed job result.
REQ-019 res_ready, input, 1: downstream accepts the result.
REQ-020 final_result, output, LANES*ACC_W: per-lane accumulated result.
REQ-021 busy, output, 1: high in every state other than IDLE.

Function
REQ-022 SHALL use FSM states IDLE, ISSUE, DRAIN, DONE.
REQ-023 IDLE -> ISSUE when start=1, latching k_len, treating k_len=0 as 1, latching shift_in, zeroing all accumulators and setting addr_A=addr_S=0.
REQ-024 ISSUE SHALL present addr_A/addr_S = step index and increment both by 1 per cycle for k steps, then enter DRAIN.
REQ-025 Read latency SHALL be fixed at 1 cycle: weight_in and data_in pair with the addresses of the previous cycle, tracked by a 1-bit valid pipe.
REQ-026 For each valid data beat, per lane: p = sum over w of (data_in[l][w][ACC_W-1:0] * signed weight(l,w)), modulo 2^ACC_W.
REQ-027 For each valid data beat, per lane: acc <= (acc << shift_l) + p, truncated to ACC_W.
REQ-028 The first beat of a job SHALL use acc = 0 as its base.
REQ-029 DRAIN SHALL last 1 cycle, absorbing the final beat, then go to DONE with res_valid=1.
REQ-030 In DONE, final_result and res_valid SHALL hold stable until res_ready=1.
REQ-031 On accept, the FSM SHALL go to IDLE and increment addr_B by 1, wrapping at 2^ADDR_W.
REQ-032 start SHALL be ignored in ISSUE, DRAIN and DONE, including the cycle of acceptance.
REQ-033 Latency from start to res_valid SHALL be k+2 cycles.

Reset
REQ-034 When rst=1, the FSM SHALL go to IDLE and addr_A, addr_S, addr_B, final_result, the accumulators, res_valid, busy and the valid pipe SHALL all be 0.
REQ-035 Reset mid-job SHALL abort the job with no result emitted; rst SHALL take priority over start.

Configuration
REQ-036 With CALC_SAT_EN defined, REQ-027 SHALL saturate signed to [-2^(ACC_W-1), 2^(ACC_W-1)-1], including shift overflow.
REQ-037 Without CALC_SAT_EN, accumulation SHALL wrap modulo 2^ACC_W and no saturation logic SHALL be present.

Structure
REQ-038 Package calc_pkg SHALL hold the FSM state enum, the default parameter constants and the shift field width (3).
REQ-039 Sub-module calc_lane SHALL implement one lane's dot product, shift and accumulate, and SHALL be instantiated LANES times via generate.

Verification
REQ-040 Single step: start, k_len=1, shift=0, all data words=1, all weights=1 -> res_valid at cycle 3, every lane result = 4.
REQ-041 k=3, shift=1, p=1 per beat -> every lane result = 7; addr_A sequence 0,1,2.
REQ-042 res_ready held low 5 cycles in DONE -> final_result stable throughout; addr_B goes 0 -> 1 only on accept; start pulses during the stall are ignored.
REQ-043 rst asserted mid-ISSUE -> all outputs 0 next cycle; a following job with k=1, p=4 produces result 4.
REQ-044 k_len=0 -> behaves as k=1.
REQ-045 CALC_SAT_EN, ACC_W=16, k=2, shift=7, p=0x7FFF -> result 0x7FFF; without the macro the result is the truncated wrap value (0x7F7F).

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared state type, default dimensions and shift field width for calc_seq_top.
package calc_pkg;

  localparam int DEF_LANES  = 8;
  localparam int DEF_WORDS  = 4;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_ACC_W  = 16;
  localparam int DEF_SW     = 5;
  localparam int DEF_ADDR_W = 32;
  localparam int DEF_KW     = 8;
  localparam int SHIFT_W    = 3;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/calc_lane.sv
// calc_lane: one lane's signed-weight dot product followed by shift-and-accumulate.
// Optional feature macro: CALC_SAT_EN (signed saturation of the accumulate step; default wraps).
module calc_lane
  import calc_pkg::*;
#(
  parameter int WORDS  = DEF_WORDS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int SW     = DEF_SW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic [SHIFT_W-1:0]      shift_i,
  input  logic [WORDS*DATA_W-1:0] data_i,
  input  logic [WORDS*SW-1:0]     weight_i,
  output logic [ACC_W-1:0]        acc_next_o
);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] prod_sum;

  // Only the low ACC_W bits of each data word feed the product.
  logic unused_data;
  assign unused_data = ^data_i;

  always_comb begin
    prod_sum = '0;
    for (int w = 0; w < WORDS; w++) begin
      prod_sum = prod_sum + ACC_W'(data_i[w*DATA_W +: ACC_W] *
                 {{(ACC_W-SW){weight_i[w*SW+SW-1]}}, weight_i[w*SW +: SW]});
    end
  end

`ifdef CALC_SAT_EN
  localparam int WIDE_W = ACC_W + (1 << SHIFT_W);
  localparam logic signed [WIDE_W-1:0] SAT_MAX = {{(WIDE_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [WIDE_W-1:0] SAT_MIN = {{(WIDE_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};

  logic signed [WIDE_W-1:0] acc_ext;
  logic signed [WIDE_W-1:0] prod_ext;
  logic signed [WIDE_W-1:0] wide_sum;

  // Wide enough that neither the 7-bit shift nor the add can overflow before clamping.
  always_comb begin
    acc_ext  = {{(WIDE_W-ACC_W){acc_q[ACC_W-1]}}, acc_q};
    prod_ext = {{(WIDE_W-ACC_W){prod_sum[ACC_W-1]}}, prod_sum};
    wide_sum = (acc_ext <<< shift_i) + prod_ext;
    if (wide_sum > SAT_MAX) begin
      acc_d = SAT_MAX[ACC_W-1:0];
    end else if (wide_sum < SAT_MIN) begin
      acc_d = SAT_MIN[ACC_W-1:0];
    end else begin
      acc_d = wide_sum[ACC_W-1:0];
    end
  end
`else
  always_comb begin
    acc_d = (acc_q << shift_i) + prod_sum;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (clr_i) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= acc_d;
    end
  end

  assign acc_next_o = acc_d;

endmodule

// File: rtl/calc_seq_top.sv
// calc_seq_top: sequences k read steps, accumulates LANES parallel dot products and hands off the result.
// Optional feature macro: CALC_SAT_EN (passed through to calc_lane for saturating accumulation).
module calc_seq_top
  import calc_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int WORDS  = DEF_WORDS,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int SW     = DEF_SW,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int KW     = DEF_KW
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [KW-1:0]                 k_len,
  input  logic [LANES*SHIFT_W-1:0]      shift_in,
  input  logic [LANES*WORDS*SW-1:0]     weight_in,
  input  logic [LANES*WORDS*DATA_W-1:0] data_in,
  output logic [ADDR_W-1:0]             addr_A,
  output logic [ADDR_W-1:0]             addr_S,
  output logic [ADDR_W-1:0]             addr_B,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [LANES*ACC_W-1:0]        final_result,
  output logic                          busy
);

  state_e                   state_q;
  state_e                   state_d;
  logic [KW-1:0]            k_q;
  logic [LANES*SHIFT_W-1:0] shift_q;
  logic [ADDR_W-1:0]        addr_q;
  logic [ADDR_W-1:0]        addr_b_q;
  logic                     valid_q;
  logic [LANES*ACC_W-1:0]   result_q;
  logic [LANES*ACC_W-1:0]   acc_next;
  logic                     job_start;
  logic                     last_step;

  assign job_start = (state_q == IDLE) && start;
  assign last_step = (addr_q == (ADDR_W'(k_q) - ADDR_W'(1)));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ISSUE;
      ISSUE:   if (last_step) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // valid_q marks that data_in this cycle answers last cycle's ISSUE address.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      shift_q  <= '0;
      addr_q   <= '0;
      addr_b_q <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= (state_q == ISSUE);
      if (job_start) begin
        k_q     <= (k_len == '0) ? KW'(1) : k_len;
        shift_q <= shift_in;
        addr_q  <= '0;
      end
      if (state_q == ISSUE) begin
        addr_q <= addr_q + ADDR_W'(1);
      end
      if (state_q == DRAIN) begin
        result_q <= acc_next;
      end
      if ((state_q == DONE) && res_ready) begin
        addr_b_q <= addr_b_q + ADDR_W'(1);
      end
    end
  end

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      calc_lane #(
        .WORDS (WORDS),
        .DATA_W(DATA_W),
        .ACC_W (ACC_W),
        .SW    (SW)
      ) u_lane (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (job_start),
        .en_i      (valid_q),
        .shift_i   (shift_q[l*SHIFT_W +: SHIFT_W]),
        .data_i    (data_in[l*WORDS*DATA_W +: WORDS*DATA_W]),
        .weight_i  (weight_in[l*WORDS*SW +: WORDS*SW]),
        .acc_next_o(acc_next[l*ACC_W +: ACC_W])
      );
    end
  endgenerate

  assign addr_A       = addr_q;
  assign addr_S       = addr_q;
  assign addr_B       = addr_b_q;
  assign res_valid    = (state_q == DONE);
  assign busy         = (state_q != IDLE);
  assign final_result = result_q;

endmodule

// File: tb/tb_calc_seq_top.sv
// tb_calc_seq_top: directed, self-checking bench for calc_seq_top at its default parameters.
module tb_calc_seq_top;

  localparam int LANES  = 8;
  localparam int WORDS  = 4;
  localparam int DATA_W = 64;
  localparam int ACC_W  = 16;
  localparam int SW     = 5;
  localparam int ADDR_W = 32;
  localparam int KW     = 8;
  localparam int DW     = LANES*WORDS*DATA_W;
  localparam int WW     = LANES*WORDS*SW;
  localparam int RW     = LANES*ACC_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [KW-1:0]     k_len;
  logic [LANES*3-1:0] shift_in;
  logic [WW-1:0]     weight_in;
  logic [DW-1:0]     data_in;
  logic [ADDR_W-1:0] addr_A;
  logic [ADDR_W-1:0] addr_S;
  logic [ADDR_W-1:0] addr_B;
  logic              res_valid;
  logic              res_ready;
  logic [RW-1:0]     final_result;
  logic              busy;

  int total = 0;
  int bad   = 0;
  logic [ADDR_W-1:0] exp_b;
  logic [RW-1:0]     exp_r;

  always #5 clk = ~clk;

  calc_seq_top dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .k_len       (k_len),
    .shift_in    (shift_in),
    .weight_in   (weight_in),
    .data_in     (data_in),
    .addr_A      (addr_A),
    .addr_S      (addr_S),
    .addr_B      (addr_B),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .final_result(final_result),
    .busy        (busy)
  );

  // Word 0 of every lane gets w0, the remaining words get wr.
  function automatic logic [DW-1:0] mk_data(input logic [DATA_W-1:0] w0, input logic [DATA_W-1:0] wr);
    logic [DW-1:0] v;
    for (int l = 0; l < LANES; l++)
      for (int w = 0; w < WORDS; w++)
        v[(l*WORDS+w)*DATA_W +: DATA_W] = (w == 0) ? w0 : wr;
    return v;
  endfunction

  function automatic logic [WW-1:0] mk_weight(input logic [SW-1:0] w0, input logic [SW-1:0] wr);
    logic [WW-1:0] v;
    for (int l = 0; l < LANES; l++)
      for (int w = 0; w < WORDS; w++)
        v[(l*WORDS+w)*SW +: SW] = (w == 0) ? w0 : wr;
    return v;
  endfunction

  function automatic logic [RW-1:0] rep(input logic [ACC_W-1:0] x);
    logic [RW-1:0] v;
    for (int l = 0; l < LANES; l++) v[l*ACC_W +: ACC_W] = x;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [KW-1:0] k, input logic [LANES*3-1:0] sh);
    k_len    = k;
    shift_in = sh;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic accept();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    exp_b = exp_b + 1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b1;
    tick();
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", res_valid); end
    total++; if (addr_A !== '0) begin bad++; $display("FAIL reset_addrA: got %h want 0", addr_A); end
    total++; if (addr_S !== '0) begin bad++; $display("FAIL reset_addrS: got %h want 0", addr_S); end
    total++; if (addr_B !== '0) begin bad++; $display("FAIL reset_addrB: got %h want 0", addr_B); end
    total++; if (final_result !== '0) begin bad++; $display("FAIL reset_result: got %h want 0", final_result); end
    rst = 1'b0;
    start = 1'b0;
    exp_b = '0;
    tick();
  endtask

  task automatic test_single_step();
    data_in   = mk_data(64'd1, 64'd1);
    weight_in = mk_weight(5'd1, 5'd1);
    launch(8'd1, '0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
    total++; if (addr_A !== 32'd0) begin bad++; $display("FAIL single_addrA: got %h want 0", addr_A); end
    tick();
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL single_early_valid: got %b want 0", res_valid); end
    tick();
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %b want 1", res_valid); end
    exp_r = rep(16'd4);
    total++; if (final_result !== exp_r) begin bad++; $display("FAIL single_result: got %h want %h", final_result, exp_r); end
    accept();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_idle: got %b want 0", busy); end
    total++; if (addr_B !== exp_b) begin bad++; $display("FAIL single_addrB: got %h want %h", addr_B, exp_b); end
  endtask

  task automatic test_multi_step();
    data_in   = mk_data(64'd1, 64'd1);
    weight_in = mk_weight(5'd1, 5'd0);
    launch(8'd3, {LANES{3'd1}});
    for (int i = 0; i < 3; i++) begin
      total++; if (addr_A !== ADDR_W'(i)) begin bad++; $display("FAIL multi_addrA[%0d]: got %h want %h", i, addr_A, i); end
      total++; if (addr_S !== ADDR_W'(i)) begin bad++; $display("FAIL multi_addrS[%0d]: got %h want %h", i, addr_S, i); end
      tick();
    end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL multi_drain_valid: got %b want 0", res_valid); end
    tick();
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL multi_valid: got %b want 1", res_valid); end
    exp_r = rep(16'd7);
    total++; if (final_result !== exp_r) begin bad++; $display("FAIL multi_result: got %h want %h", final_result, exp_r); end
    accept();
    total++; if (addr_B !== exp_b) begin bad++; $display("FAIL multi_addrB: got %h want %h", addr_B, exp_b); end
  endtask

  // Weights of -1 give p = -4; lane l shifts by l, so k=2 yields -(4<<l) - 4.
  task automatic test_signed();
    logic [LANES*3-1:0] sh;
    int v;
    for (int l = 0; l < LANES; l++) begin
      sh[l*3 +: 3] = 3'(l);
      v = -(4 << l) - 4;
      exp_r[l*ACC_W +: ACC_W] = v[ACC_W-1:0];
    end
    data_in   = mk_data(64'd1, 64'd1);
    weight_in = mk_weight(5'h1F, 5'h1F);
    launch(8'd2, sh);
    tick();
    tick();
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL signed_early_valid: got %b want 0", res_valid); end
    tick();
    total++; if (final_result !== exp_r) begin bad++; $display("FAIL signed_result: got %h want %h", final_result, exp_r); end
    accept();
  endtask

  task automatic test_stall();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_b = '0;
    data_in   = mk_data(64'd1, 64'd1);
    weight_in = mk_weight(5'd1, 5'd1);
    launch(8'd1, '0);
    tick();
    tick();
    exp_r = rep(16'd4);
    for (int i = 0; i < 5; i++) begin
      total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d]: got %b want 1", i, res_valid); end
      total++; if (final_result !== exp_r) begin bad++; $display("FAIL stall_result[%0d]: got %h want %h", i, final_result, exp_r); end
      total++; if (addr_B !== 32'd0) begin bad++; $display("FAIL stall_addrB[%0d]: got %h want 0", i, addr_B); end
      start = (i % 2 == 0);
      tick();
    end
    start = 1'b1;
    accept();
    start = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stall_accept_start: got %b want 0", busy); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL stall_accept_valid: got %b want 0", res_valid); end
    total++; if (addr_B !== 32'd1) begin bad++; $display("FAIL stall_addrB_accept: got %h want 1", addr_B); end
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL stall_stay_idle: got %b want 0", busy); end
  endtask

  task automatic test_mid_reset();
    data_in   = mk_data(64'd1, 64'd1);
    weight_in = mk_weight(5'd1, 5'd1);
    launch(8'd5, '0);
    tick();
    tick();
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    exp_b = '0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %b want 0", res_valid); end
    total++; if (addr_A !== '0) begin bad++; $display("FAIL midrst_addrA: got %h want 0", addr_A); end
    total++; if (addr_B !== '0) begin bad++; $display("FAIL midrst_addrB: got %h want 0", addr_B); end
    total++; if (final_result !== '0) begin bad++; $display("FAIL midrst_result: got %h want 0", final_result); end
    for (int i = 0; i < 6; i++) begin
      tick();
      total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL midrst_no_result[%0d]: got %b want 0", i, res_valid); end
    end
    launch(8'd1, '0);
    tick();
    tick();
    exp_r = rep(16'd4);
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL midrst_job_valid: got %b want 1", res_valid); end
    total++; if (final_result !== exp_r) begin bad++; $display("FAIL midrst_job_result: got %h want %h", final_result, exp_r); end
    accept();
    total++; if (addr_B !== exp_b) begin bad++; $display("FAIL midrst_addrB_accept: got %h want %h", addr_B, exp_b); end
  endtask

  task automatic test_k_zero();
    data_in   = mk_data(64'd1, 64'd1);
    weight_in = mk_weight(5'd2, 5'd2);
    launch(8'd0, '0);
    total++; if (addr_A !== 32'd0) begin bad++; $display("FAIL kzero_addrA: got %h want 0", addr_A); end
    tick();
    total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL kzero_early_valid: got %b want 0", res_valid); end
    tick();
    exp_r = rep(16'd8);
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL kzero_valid: got %b want 1", res_valid); end
    total++; if (final_result !== exp_r) begin bad++; $display("FAIL kzero_result: got %h want %h", final_result, exp_r); end
    accept();
  endtask

  // Upper data bits must be ignored; second beat overflows the shift.
  task automatic test_wrap();
    data_in   = mk_data(64'hABCD_0000_0000_7FFF, 64'd0);
    weight_in = mk_weight(5'd1, 5'd0);
    launch(8'd2, {LANES{3'd7}});
    tick();
    tick();
    tick();
`ifdef CALC_SAT_EN
    exp_r = rep(16'h7FFF);
`else
    exp_r = rep(16'h7F7F);
`endif
    total++; if (res_valid !== 1'b1) begin bad++; $display("FAIL wrap_valid: got %b want 1", res_valid); end
    total++; if (final_result !== exp_r) begin bad++; $display("FAIL wrap_result: got %h want %h", final_result, exp_r); end
    accept();
    total++; if (addr_B !== exp_b) begin bad++; $display("FAIL wrap_addrB: got %h want %h", addr_B, exp_b); end
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    res_ready = 1'b0;
    k_len     = '0;
    shift_in  = '0;
    weight_in = '0;
    data_in   = '0;
    exp_b     = '0;
    exp_r     = '0;
    test_reset();
    test_single_step();
    test_multi_step();
    test_signed();
    test_stall();
    test_mid_reset();
    test_k_zero();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
